// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//
// MIPS instruction-decode stage between the IF/ID register and EX. Decodes
// the logic-immediate group (ORI/ANDI/XORI), LUI, and the R-type logic and
// shift functions. It reads the register file combinationally and forwards
// results from EX and MEM to resolve RAW hazards. The decoded micro-op is
// held in a single valid/ready output register that can be flushed.
//
// Parameters
//   XLEN     datapath width; must be at least 32
//   ALUOP_W  width of the aluop encoding
//   FWD_EN   1 = forward from EX/MEM, 0 = register-file data only
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      instruction handshake from IF/ID
//   in_pc, in_inst           instruction PC and word
//   rreg1_en/_addr           register-file read port 1 (rs)
//   rreg2_en/_addr           register-file read port 2 (rt)
//   reg1_data, reg2_data     register-file read data, same cycle
//   ex_wreg/_waddr/_wdata    EX-stage result, forwarding source
//   mem_wreg/_waddr/_wdata   MEM-stage result, forwarding source
//   flush                    kills the held op and the incoming instruction
//   out_valid / out_ready    micro-op handshake toward EX
//   out_pc                   PC of the micro-op
//   out_alusel               000 nop, 001 logic, 010 shift
//   out_aluop                operation code
//   out_reg1, out_reg2       resolved operands
//   out_wreg, out_waddr      destination write enable and register
//   out_invalid              unsupported instruction
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 8,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_inst,
  output logic               rreg1_en,
  output logic               rreg2_en,
  output logic [4:0]         rreg1_addr,
  output logic [4:0]         rreg2_addr,
  input  logic [XLEN-1:0]    reg1_data,
  input  logic [XLEN-1:0]    reg2_data,
  input  logic               ex_wreg,
  input  logic [4:0]         ex_waddr,
  input  logic [XLEN-1:0]    ex_wdata,
  input  logic               mem_wreg,
  input  logic [4:0]         mem_waddr,
  input  logic [XLEN-1:0]    mem_wdata,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [2:0]         out_alusel,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [XLEN-1:0]    out_reg1,
  output logic [XLEN-1:0]    out_reg2,
  output logic               out_wreg,
  output logic [4:0]         out_waddr,
  output logic               out_invalid
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU selector classes
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_NOP = '0;
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(8'h24);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(8'h25);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(8'h26);
  localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(8'h27);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(8'h7C);
  localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(8'h02);
  localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(8'h03);

  // Where each operand comes from once the instruction is decoded
  typedef enum logic [1:0] {
    R1_ZERO,
    R1_REG,
    R1_SHAMT
  } reg1_sel_t;

  typedef enum logic [1:0] {
    R2_ZERO,
    R2_REG,
    R2_IMM,
    R2_LUI
  } reg2_sel_t;

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_func;
  logic [15:0] w_imm;

  // Decoder outputs
  logic [2:0]         w_alusel;
  logic [ALUOP_W-1:0] w_aluop;
  logic               w_wregDec;
  logic [4:0]         w_waddr;
  logic               w_re1;
  logic               w_re2;
  logic               w_invalid;
  reg1_sel_t          w_reg1Sel;
  reg2_sel_t          w_reg2Sel;

  // Extended constants and forwarded source data
  logic [XLEN-1:0] w_immExt;
  logic [XLEN-1:0] w_luiExt;
  logic [XLEN-1:0] w_shamtExt;
  logic            w_exHit1;
  logic            w_exHit2;
  logic            w_memHit1;
  logic            w_memHit2;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic [XLEN-1:0] w_reg1;
  logic [XLEN-1:0] w_reg2;

  // Handshake
  logic w_inReady;
  logic w_accept;

  // Output register
  logic               r_valid;
  logic [31:0]        r_pc;
  logic [2:0]         r_alusel;
  logic [ALUOP_W-1:0] r_aluop;
  logic [XLEN-1:0]    r_reg1;
  logic [XLEN-1:0]    r_reg2;
  logic               r_wreg;
  logic [4:0]         r_waddr;
  logic               r_invalid;

  assign w_op    = in_inst[31:26];
  assign w_rs    = in_inst[25:21];
  assign w_rt    = in_inst[20:16];
  assign w_rd    = in_inst[15:11];
  assign w_shamt = in_inst[10:6];
  assign w_func  = in_inst[5:0];
  assign w_imm   = in_inst[15:0];

  // Main decoder. Everything defaults to the "unsupported" shape (no reads,
  // no write, zero operands, invalid set); each recognised encoding then
  // overrides only what it needs.
  always_comb begin
    w_alusel  = SEL_NOP;
    w_aluop   = ALU_NOP;
    w_wregDec = 1'b0;
    w_waddr   = 5'd0;
    w_re1     = 1'b0;
    w_re2     = 1'b0;
    w_invalid = 1'b1;
    w_reg1Sel = R1_ZERO;
    w_reg2Sel = R2_ZERO;
    case (w_op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        w_alusel  = SEL_LOGIC;
        w_aluop   = (w_op == OP_ANDI) ? ALU_AND :
                    (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
        w_wregDec = 1'b1;
        w_waddr   = w_rt;
        w_re1     = 1'b1;
        w_invalid = 1'b0;
        w_reg1Sel = R1_REG;
        w_reg2Sel = R2_IMM;
      end
      OP_LUI: begin
        // LUI is an OR of zero with the shifted immediate; no reads needed.
        w_alusel  = SEL_LOGIC;
        w_aluop   = ALU_OR;
        w_wregDec = 1'b1;
        w_waddr   = w_rt;
        w_invalid = 1'b0;
        w_reg2Sel = R2_LUI;
      end
      OP_SPECIAL: begin
        case (w_func)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            w_alusel  = SEL_LOGIC;
            w_aluop   = (w_func == FN_AND) ? ALU_AND :
                        (w_func == FN_OR)  ? ALU_OR  :
                        (w_func == FN_XOR) ? ALU_XOR : ALU_NOR;
            w_wregDec = 1'b1;
            w_waddr   = w_rd;
            w_re1     = 1'b1;
            w_re2     = 1'b1;
            w_invalid = 1'b0;
            w_reg1Sel = R1_REG;
            w_reg2Sel = R2_REG;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shift amount travels in reg1 so EX sees a uniform operand pair.
            w_alusel  = SEL_SHIFT;
            w_aluop   = (w_func == FN_SLL) ? ALU_SLL :
                        (w_func == FN_SRL) ? ALU_SRL : ALU_SRA;
            w_wregDec = 1'b1;
            w_waddr   = w_rd;
            w_re2     = 1'b1;
            w_invalid = 1'b0;
            w_reg1Sel = R1_SHAMT;
            w_reg2Sel = R2_REG;
          end
          default: begin
            w_invalid = 1'b1;
          end
        endcase
      end
      default: begin
        w_invalid = 1'b1;
      end
    endcase
  end

  // Zero-extend the immediate forms up to the datapath width.
  always_comb begin
    w_immExt          = '0;
    w_immExt[15:0]    = w_imm;
    w_luiExt          = '0;
    w_luiExt[31:16]   = w_imm;
    w_shamtExt        = '0;
    w_shamtExt[4:0]   = w_shamt;
  end

  // Forwarding match detection. EX is newer than MEM so it wins; $0 is
  // hard-wired zero and must never pick up a stale forwarded value.
  assign w_exHit1  = FWD_EN && ex_wreg  && (ex_waddr  == w_rs) && (w_rs != 5'd0);
  assign w_memHit1 = FWD_EN && mem_wreg && (mem_waddr == w_rs) && (w_rs != 5'd0);
  assign w_exHit2  = FWD_EN && ex_wreg  && (ex_waddr  == w_rt) && (w_rt != 5'd0);
  assign w_memHit2 = FWD_EN && mem_wreg && (mem_waddr == w_rt) && (w_rt != 5'd0);

  assign w_src1 = w_exHit1  ? ex_wdata  :
                  w_memHit1 ? mem_wdata : reg1_data;
  assign w_src2 = w_exHit2  ? ex_wdata  :
                  w_memHit2 ? mem_wdata : reg2_data;

  // Final operand selection from the decoder's source choice.
  always_comb begin
    w_reg1 = '0;
    w_reg2 = '0;
    case (w_reg1Sel)
      R1_REG:   w_reg1 = w_src1;
      R1_SHAMT: w_reg1 = w_shamtExt;
      default:  w_reg1 = '0;
    endcase
    case (w_reg2Sel)
      R2_REG:  w_reg2 = w_src2;
      R2_IMM:  w_reg2 = w_immExt;
      R2_LUI:  w_reg2 = w_luiExt;
      default: w_reg2 = '0;
    endcase
  end

  // Register-file read port. Addresses follow the raw fields; enables are
  // suppressed when there is no instruction so the file can idle.
  assign rreg1_addr = w_rs;
  assign rreg2_addr = w_rt;
  assign rreg1_en   = in_valid && w_re1;
  assign rreg2_en   = in_valid && w_re2;

  // The register can take a new op whenever it is empty or being drained
  // this cycle, which keeps a streaming pipeline bubble-free. A flush
  // refuses the incoming instruction outright.
  assign w_inReady = !flush && (!r_valid || out_ready);
  assign w_accept  = in_valid && w_inReady;
  assign in_ready  = w_inReady;

  // Output register. Priority: reset, flush, accept, drain, otherwise hold.
  // Flush and drain only clear the valid bit; the data fields keep their
  // last values since nothing downstream looks at them without valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_alusel  <= '0;
      r_aluop   <= '0;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_wreg    <= 1'b0;
      r_waddr   <= '0;
      r_invalid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_alusel  <= w_alusel;
      r_aluop   <= w_aluop;
      r_reg1    <= w_reg1;
      r_reg2    <= w_reg2;
      r_wreg    <= w_wregDec && (w_waddr != 5'd0);
      r_waddr   <= w_waddr;
      r_invalid <= w_invalid;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_alusel  = r_alusel;
  assign out_aluop   = r_aluop;
  assign out_reg1    = r_reg1;
  assign out_reg2    = r_reg2;
  assign out_wreg    = r_wreg;
  assign out_waddr   = r_waddr;
  assign out_invalid = r_invalid;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//
// Scoreboard bench for id_stage. A small reference decoder predicts each
// micro-op at the moment the stage accepts it; the prediction is queued and
// compared against the output register every cycle it is expected valid,
// then retired when EX consumes it or a flush kills it.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        rreg1_en;
  logic        rreg2_en;
  logic [4:0]  rreg1_addr;
  logic [4:0]  rreg2_addr;
  logic [31:0] reg1_data;
  logic [31:0] reg2_data;
  logic        ex_wreg;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_alusel;
  logic [7:0]  out_aluop;
  logic [31:0] out_reg1;
  logic [31:0] out_reg2;
  logic        out_wreg;
  logic [4:0]  out_waddr;
  logic        out_invalid;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        wreg;
    logic [4:0]  waddr;
    logic        inv;
    logic        re1;
    logic        re2;
  } exp_t;

  exp_t sbQueue[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   accepted;
  logic [31:0] pcCounter = 32'h0000_1000;

  id_stage #(.XLEN(32), .ALUOP_W(8), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .rreg1_en(rreg1_en), .rreg2_en(rreg2_en),
    .rreg1_addr(rreg1_addr), .rreg2_addr(rreg2_addr),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alusel(out_alusel), .out_aluop(out_aluop),
    .out_reg1(out_reg1), .out_reg2(out_reg2),
    .out_wreg(out_wreg), .out_waddr(out_waddr), .out_invalid(out_invalid)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Operand source as the architecture defines it: youngest producer first.
  function automatic logic [31:0] pickOperand(input logic [4:0] a, input logic [31:0] rf);
    if (a != 5'd0 && ex_wreg && ex_waddr == a) return ex_wdata;
    if (a != 5'd0 && mem_wreg && mem_waddr == a) return mem_wdata;
    return rf;
  endfunction

  // Reference decoder written directly from the instruction tables.
  function automatic exp_t modelDecode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16];
    rd = inst[15:11]; sh = inst[10:6]; fn = inst[5:0]; imm = inst[15:0];
    e = '0;
    e.pc = pc;
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
      e.alusel = 3'b001;
      e.aluop  = (op == 6'h0C) ? 8'h24 : (op == 6'h0D) ? 8'h25 : 8'h26;
      e.r1 = pickOperand(rs, reg1_data);
      e.r2 = {16'h0, imm};
      e.waddr = rt; e.wreg = 1'b1; e.re1 = 1'b1;
    end else if (op == 6'h0F) begin
      e.alusel = 3'b001; e.aluop = 8'h25;
      e.r2 = {imm, 16'h0};
      e.waddr = rt; e.wreg = 1'b1;
    end else if (op == 6'h00 && fn[5:2] == 4'b1001) begin
      e.alusel = 3'b001; e.aluop = {2'b00, fn};
      e.r1 = pickOperand(rs, reg1_data);
      e.r2 = pickOperand(rt, reg2_data);
      e.waddr = rd; e.wreg = 1'b1; e.re1 = 1'b1; e.re2 = 1'b1;
    end else if (op == 6'h00 && (fn == 6'd0 || fn == 6'd2 || fn == 6'd3)) begin
      e.alusel = 3'b010;
      e.aluop  = (fn == 6'd0) ? 8'h7C : {2'b00, fn};
      e.r1 = {27'h0, sh};
      e.r2 = pickOperand(rt, reg2_data);
      e.waddr = rd; e.wreg = 1'b1; e.re2 = 1'b1;
    end else begin
      e.inv = 1'b1;
    end
    if (e.waddr == 5'd0) e.wreg = 1'b0;
    return e;
  endfunction

  // One clock cycle with whatever inputs are currently driven. At the
  // falling edge the outputs are checked against the scoreboard, then the
  // handshake outcome of this cycle is applied to the queue.
  task automatic applyStimulus();
    exp_t e;
    exp_t f;
    bit   expValid;
    bit   expReady;
    @(negedge clk);
    expValid = (sbQueue.size() != 0);
    expReady = !flush && (!expValid || out_ready);
    checkOutput("out_valid", out_valid, expValid);
    checkOutput("in_ready", in_ready, expReady);
    if (expValid) begin
      f = sbQueue[0];
      checkOutput("out_pc", out_pc, f.pc);
      checkOutput("out_alusel", out_alusel, f.alusel);
      checkOutput("out_aluop", out_aluop, f.aluop);
      checkOutput("out_reg1", out_reg1, f.r1);
      checkOutput("out_reg2", out_reg2, f.r2);
      checkOutput("out_wreg", out_wreg, f.wreg);
      checkOutput("out_invalid", out_invalid, f.inv);
      if (!f.inv) checkOutput("out_waddr", out_waddr, f.waddr);
    end
    e = modelDecode(in_inst, in_pc);
    checkOutput("rreg1_en", rreg1_en, in_valid && e.re1);
    checkOutput("rreg2_en", rreg2_en, in_valid && e.re2);
    checkOutput("rreg1_addr", rreg1_addr, in_inst[25:21]);
    checkOutput("rreg2_addr", rreg2_addr, in_inst[20:16]);
    if (expValid && (out_ready || flush)) void'(sbQueue.pop_front());
    accepted = in_valid && expReady;
    if (accepted) sbQueue.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pcCounter;
    pcCounter = pcCounter + 32'd4;
  endtask

  task automatic clearFwd();
    ex_wreg = 1'b0; ex_waddr = '0; ex_wdata = '0;
    mem_wreg = 1'b0; mem_waddr = '0; mem_wdata = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_wreg"}, out_wreg, 0);
    checkOutput({tag, "_invalid"}, out_invalid, 0);
    checkOutput({tag, "_alusel"}, out_alusel, 0);
    checkOutput({tag, "_aluop"}, out_aluop, 0);
    checkOutput({tag, "_reg1"}, out_reg1, 0);
    checkOutput({tag, "_reg2"}, out_reg2, 0);
    checkOutput({tag, "_waddr"}, out_waddr, 0);
    checkOutput({tag, "_pc"}, out_pc, 0);
  endtask

  function automatic logic [31:0] randInst();
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sh = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 13))
      0:  return {6'h0D, rs, rt, imm};
      1:  return {6'h0C, rs, rt, imm};
      2:  return {6'h0E, rs, rt, imm};
      3:  return {6'h0F, 5'd0, rt, imm};
      4:  return {6'h00, rs, rt, rd, 5'd0, 6'b100100};
      5:  return {6'h00, rs, rt, rd, 5'd0, 6'b100101};
      6:  return {6'h00, rs, rt, rd, 5'd0, 6'b100110};
      7:  return {6'h00, rs, rt, rd, 5'd0, 6'b100111};
      8:  return {6'h00, 5'd0, rt, rd, sh, 6'b000000};
      9:  return {6'h00, 5'd0, rt, rd, sh, 6'b000010};
      10: return {6'h00, 5'd0, rt, rd, sh, 6'b000011};
      11: return {6'h3F, rs, rt, imm};
      12: return {6'h00, rs, rt, rd, 5'd0, 6'b101010};
      default: return 32'h0000_0000;
    endcase
  endfunction

  initial begin
    int sent;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    reg1_data = '0; reg2_data = '0; flush = 1'b0; out_ready = 1'b1;
    clearFwd();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);

    // ORI $3,$2,0x20 with $2 = 0x1100
    reg1_data = 32'h0000_1100;
    drive(32'h3443_0020);
    applyStimulus();
    checkOutput("ori_valid", out_valid, 1);
    checkOutput("ori_alusel", out_alusel, 3'b001);
    checkOutput("ori_aluop", out_aluop, 8'h25);
    checkOutput("ori_reg1", out_reg1, 32'h1100);
    checkOutput("ori_reg2", out_reg2, 32'h20);
    checkOutput("ori_wreg", out_wreg, 1);
    checkOutput("ori_waddr", out_waddr, 3);

    // Forwarding priority: and $1,$2,$3
    ex_wreg = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'hAAAA;
    mem_wreg = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h5555;
    reg1_data = 32'h1111; reg2_data = 32'h2222;
    drive({6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'b100100});
    applyStimulus();
    checkOutput("fwd_ex_reg1", out_reg1, 32'hAAAA);
    checkOutput("fwd_ex_reg2", out_reg2, 32'h2222);
    ex_wreg = 1'b0;
    drive({6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'b100100});
    applyStimulus();
    checkOutput("fwd_mem_reg1", out_reg1, 32'h5555);
    ex_wreg = 1'b1; ex_waddr = 5'd0; mem_waddr = 5'd0;
    reg1_data = 32'h0; reg2_data = 32'h0;
    drive({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'b100100});
    applyStimulus();
    checkOutput("fwd_zero_reg1", out_reg1, 32'h0);
    checkOutput("fwd_zero_reg2", out_reg2, 32'h0);
    clearFwd();

    // Shift, NOP word and an unsupported opcode
    reg2_data = 32'h8000_0000;
    drive({6'h00, 5'd0, 5'd5, 5'd4, 5'd31, 6'b000011});
    applyStimulus();
    checkOutput("sra_reg1", out_reg1, 31);
    checkOutput("sra_aluop", out_aluop, 8'h03);
    checkOutput("sra_alusel", out_alusel, 3'b010);
    drive(32'h0000_0000);
    applyStimulus();
    checkOutput("nop_wreg", out_wreg, 0);
    drive(32'hFC00_0000);
    applyStimulus();
    checkOutput("inv_invalid", out_invalid, 1);
    checkOutput("inv_wreg", out_wreg, 0);
    checkOutput("inv_valid", out_valid, 1);
    in_valid = 1'b0;
    applyStimulus();

    // Three ORIs streamed with a two-cycle stall in the middle
    sent = 0;
    for (int c = 0; c < 20 && (sent < 3 || sbQueue.size() != 0); c++) begin
      out_ready = !(c == 2 || c == 3);
      if (sent < 3) begin
        reg1_data = 32'h100 * (sent + 1);
        in_valid = 1'b1;
        in_inst = {6'h0D, 5'd1, 5'(sent + 3), 16'h10 + 16'(sent)};
        in_pc = pcCounter + 32'(4 * sent);
      end else begin
        in_valid = 1'b0;
      end
      applyStimulus();
      if (c == 2 || c == 3) checkOutput("stall_in_ready", in_ready, 0);
      if (accepted) sent++;
    end
    pcCounter = pcCounter + 32'd12;
    checkOutput("stream_sent", sent, 3);
    checkOutput("stream_drained", out_valid, 0);

    // Flush of a held op while a new instruction is presented
    out_ready = 1'b0;
    drive(32'h3463_0001);
    applyStimulus();
    drive(32'h3463_0002);
    flush = 1'b1;
    applyStimulus();
    checkOutput("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    applyStimulus();
    checkOutput("flush_absent", out_valid, 0);

    // Randomised traffic with forwarding, backpressure and flushes
    for (int c = 0; c < 80; c++) begin
      if ($urandom_range(0, 3) != 0) drive(randInst()); else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      reg1_data = $urandom; reg2_data = $urandom;
      ex_wreg = 1'($urandom); ex_waddr = 5'($urandom_range(0, 7)); ex_wdata = $urandom;
      mem_wreg = 1'($urandom); mem_waddr = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
      applyStimulus();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; clearFwd();
    repeat (2) applyStimulus();

    // Reset in the middle of a hold
    out_ready = 1'b0;
    drive(32'h3442_0055);
    applyStimulus();
    in_valid = 1'b0;
    applyStimulus();
    rst = 1'b1; flush = 1'b1;
    drive(32'h3442_0066);
    @(posedge clk);
    #1;
    checkAllZero("rst_hold");
    sbQueue.delete();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("rst_hold_in_ready", in_ready, 1);
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered, parametrised MIPS instruction-decode stage sitting between the IF/ID register and the EX stage. It decodes the logic-immediate, LUI and R-type logic/shift subset, and reads the register file combinationally. It resolves RAW hazards by forwarding from EX and MEM, and presents one decoded micro-op per accepted instruction through a valid/ready output register with flush support.

## Interface
- XLEN, 32, datapath width; immediates and shamt are extended to XLEN.
- ALUOP_W, 8, width of aluop encoding.
- FWD_EN, 1, 1 enables EX/MEM forwarding; 0 uses register-file data only.

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction on in_pc/in_inst is valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_pc  in  32  instruction PC
- in_inst  in  32  instruction word
- rreg1_en / rreg2_en  out  1  register-file read enables (combinational)
- rreg1_addr / rreg2_addr  out  5  read addresses: rs / rt fields (combinational)
- reg1_data / reg2_data  in  XLEN  register-file read data, same cycle
- ex_wreg, ex_waddr[4:0], ex_wdata[XLEN]  in  EX-stage result for forwarding
- mem_wreg, mem_waddr[4:0], mem_wdata[XLEN]  in  MEM-stage result for forwarding
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  decoded micro-op valid
- out_ready  in  1  EX accepts the micro-op
- out_pc  out  32  PC of micro-op
- out_alusel  out  3  000 nop, 001 logic, 010 shift
- out_aluop  out  ALUOP_W  operation code
- out_reg1 / out_reg2  out  XLEN  resolved operands
- out_wreg  out  1  writes a destination register
- out_waddr  out  5  destination register
- out_invalid  out  1  unsupported instruction

## Operation
- Decode: op = inst[31:26], rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], func = [5:0].
- ORI 001101: logic, aluop 0x25. ANDI 001100: aluop 0x24. XORI 001110: aluop 0x26.
  - For all three: reg1 = rs, reg2 = zero-extended imm16, dest = rt.
- LUI 001111: logic, aluop 0x25, reg1 = 0, reg2 = {imm16, 16'h0} zero-extended, dest = rt, no reads.
- op 000000, logic funcs (reg1 = rs, reg2 = rt, dest = rd, both reads enabled):
  - AND 100100 → 0x24; OR 100101 → 0x25; XOR 100110 → 0x26; NOR 100111 → 0x27.
- op 000000, shift funcs (alusel 010, reg1 = zero-extended shamt, reg2 = rt, dest = rd, only rreg2 enabled):
  - SLL 000000 → 0x7C; SRL 000010 → 0x02; SRA 000011 → 0x03.
- Anything else:
  - Outputs: alusel 0, aluop 0, wreg 0, reg1 = reg2 = 0, invalid 1, no reads.
  - The instruction is still accepted and passed through, with out_valid asserted.
- out_wreg forced 0 when the destination is register 0, so the NOP word 0x00000000 produces no write.
- Operand resolution, per enabled source, in priority order:
  - EX match (ex_wreg, ex_waddr == addr, addr != 0) → ex_wdata;
  - else MEM match → mem_wdata;
  - else regN_data.
  - Address 0 is never forwarded. FWD_EN = 0 removes both matches.
- rreg*_addr are always driven from rs/rt. rreg*_en are 0 when in_valid is 0.

## Timing
- Latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N with out_valid = 1.
- in_ready = !flush && (!out_valid || out_ready); purely combinational, no bubble when streaming.
- Accept when in_valid && in_ready: all out_* load the decoded values.
- Hold when out_valid && !out_ready: all out_* stable. Operands are not re-resolved while held; the pipeline controller guarantees no producer retires during a hold.
- Consumed with no new input (out_valid && out_ready && !in_valid): out_valid drops to 0 next cycle; data fields hold their last values.
- Flush (synchronous) takes priority over both accept and hold:
  - next cycle out_valid = 0;
  - the input presented in the flush cycle is not accepted (in_ready = 0).
- Flush and out_ready in the same cycle: the micro-op counts as consumed and the flush still clears the register.
- Reset: out_valid, out_wreg, out_invalid = 0; out_alusel, out_aluop, out_reg1, out_reg2, out_waddr, out_pc = 0.
  - Reset overrides flush and input.
  - Reset mid-hold discards the held op.

## Test plan
- ORI: reg1_data = 0x0000_1100, inst 0x3443_0020 (ori $3,$2,0x20), out_ready = 1 → one cycle later:
  - out_valid 1, alusel 001, aluop 0x25, reg1 0x1100, reg2 0x20, wreg 1, waddr 3.
- Forwarding priority: inst and $1,$2,$3 with ex_waddr = mem_waddr = 2, ex_wdata 0xAAAA, mem_wdata 0x5555, regfile data 0x1111 → out_reg1 = 0xAAAA.
  - Repeat with ex_wreg = 0 → 0x5555.
  - Repeat with the sources changed to $0 → 0 / regfile value.
- Backpressure: stream 3 ORIs with out_ready low for 2 cycles mid-stream.
  - Held op is stable and in_ready = 0 during the stall.
  - No instruction is dropped or duplicated; output order is preserved.
- Flush: out_valid = 1, out_ready = 0, flush = 1 with in_valid = 1 → next cycle out_valid = 0 and the presented instruction is absent from the output stream.
- Shift/NOP/invalid cases:
  - SRA $4,$5,31 → reg1 = 31, aluop 0x03, alusel 010.
  - 0x00000000 → wreg 0.
  - Opcode 0x3F → out_invalid 1, wreg 0, out_valid 1.
- Reset asserted during a hold → all outputs 0 on the next edge; in_ready = 1 after release.
